// File: rtl/irq_dispatch.sv
// irq_dispatch: AXI4-Lite master that enables the interrupt controller, fetches vectors on intr_i, offers them to the core and acknowledges completion.
//   clk_i, rst_ni        clock, synchronous active-low reset
//   intr_i               interrupt line from the controller
//   m_aw*/m_w*/m_b*      write channels (MER enable, IAR acknowledge)
//   m_ar*/m_r*           read channels (IVR fetch)
//   irq_valid_o/irq_vector_o/irq_accept_i/irq_done_i   core interrupt handshake
//   busy_o               high outside IDLE
//   bus_err_o            one-cycle pulse on nonzero BRESP/RRESP
module irq_dispatch #(
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter logic [7:0]  IAR_OFFSET = 8'h0c,
   parameter logic [7:0]  IVR_OFFSET = 8'h18,
   parameter logic [7:0]  MER_OFFSET = 8'h1c,
   parameter int unsigned HOLDOFF    = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        intr_i,
   output logic        m_awvalid_o,
   output logic [31:0] m_awaddr_o,
   input  logic        m_awready_i,
   output logic        m_wvalid_o,
   output logic [31:0] m_wdata_o,
   output logic [3:0]  m_wstrb_o,
   input  logic        m_wready_i,
   input  logic        m_bvalid_i,
   input  logic [1:0]  m_bresp_i,
   output logic        m_bready_o,
   output logic        m_arvalid_o,
   output logic [31:0] m_araddr_o,
   input  logic        m_arready_i,
   input  logic        m_rvalid_i,
   input  logic [31:0] m_rdata_i,
   input  logic [1:0]  m_rresp_i,
   output logic        m_rready_o,
   output logic        irq_valid_o,
   output logic [1:0]  irq_vector_o,
   input  logic        irq_accept_i,
   input  logic        irq_done_i,
   output logic        busy_o,
   output logic        bus_err_o
);
   typedef enum logic [3:0] {INIT_W, INIT_B, IDLE, RD_A, RD_D, OFFER, SERVICE, ACK_W, ACK_B, HOLD} state_t;
   localparam logic [31:0] MER_ADDR  = BASE_ADDR + {24'h0, MER_OFFSET};
   localparam logic [31:0] IAR_ADDR  = BASE_ADDR + {24'h0, IAR_OFFSET};
   localparam logic [31:0] IVR_ADDR  = BASE_ADDR + {24'h0, IVR_OFFSET};
   localparam logic [3:0]  HOLD_LOAD = 4'(HOLDOFF - 1);
   state_t      state_q, state_d;
   logic        boot_q;
   logic        aw_q, aw_d, w_q, w_d, err_q, err_d;
   logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d, cnt_q, cnt_d;
   logic [1:0]  vec_q, vec_d;
   assign m_awvalid_o  = aw_q;
   assign m_wvalid_o   = w_q;
   assign m_awaddr_o   = awaddr_q;
   assign m_wdata_o    = wdata_q;
   assign m_wstrb_o    = wstrb_q;
   assign m_bready_o   = (state_q == INIT_B) || (state_q == ACK_B);
   assign m_arvalid_o  = state_q == RD_A;
   assign m_araddr_o   = m_arvalid_o ? IVR_ADDR : 32'h0;
   assign m_rready_o   = state_q == RD_D;
   assign irq_valid_o  = state_q == OFFER;
   assign irq_vector_o = vec_q;
   assign busy_o       = state_q != IDLE;
   assign bus_err_o    = err_q;
   always_comb begin
      state_d  = state_q;
      aw_d     = aw_q & ~m_awready_i;
      w_d      = w_q & ~m_wready_i;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      cnt_d    = cnt_q;
      vec_d    = vec_q;
      err_d    = (m_bready_o & m_bvalid_i & |m_bresp_i) | (m_rready_o & m_rvalid_i & |m_rresp_i);
      case (state_q)
         // boot_q marks the first cycle out of reset: launch the MER write
         INIT_W: if (boot_q) begin
            aw_d     = 1'b1;
            w_d      = 1'b1;
            awaddr_d = MER_ADDR;
            wdata_d  = 32'h1;
            wstrb_d  = 4'hf;
         end else if (!aw_d && !w_d) state_d = INIT_B;
         INIT_B:  if (m_bvalid_i) state_d = IDLE;
         IDLE:    if (intr_i) state_d = RD_A;
         RD_A:    if (m_arready_i) state_d = RD_D;
         RD_D: if (m_rvalid_i) begin
            if (|m_rresp_i || m_rdata_i == 32'hffff_ffff) begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
            end else begin
               vec_d   = m_rdata_i[1:0];
               state_d = OFFER;
            end
         end
         OFFER:   if (irq_accept_i) state_d = SERVICE;
         SERVICE: if (irq_done_i) begin
            state_d  = ACK_W;
            aw_d     = 1'b1;
            w_d      = 1'b1;
            awaddr_d = IAR_ADDR;
            wdata_d  = 32'h1 << vec_q;
            wstrb_d  = 4'hf;
         end
         ACK_W:   if (!aw_d && !w_d) state_d = ACK_B;
         ACK_B: if (m_bvalid_i) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
         end
         HOLD: begin
            state_d = (cnt_q == 4'd0) ? IDLE : HOLD;
            cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
         end
         default: state_d = INIT_W;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= INIT_W;
         boot_q   <= 1'b1;
         aw_q     <= 1'b0;
         w_q      <= 1'b0;
         awaddr_q <= 32'h0;
         wdata_q  <= 32'h0;
         wstrb_q  <= 4'h0;
         cnt_q    <= 4'h0;
         vec_q    <= 2'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         boot_q   <= 1'b0;
         aw_q     <= aw_d;
         w_q      <= w_d;
         awaddr_q <= awaddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         cnt_q    <= cnt_d;
         vec_q    <= vec_d;
         err_q    <= err_d;
      end
   end
endmodule
